// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - state encodings shared by the wash controller and the phase timer
package wash_pkg;

    typedef enum logic [2:0] {
        ST_START      = 3'd0,
        ST_READY      = 3'd1,
        ST_FILL_WATER = 3'd2,
        ST_HEAT_WATER = 3'd3,
        ST_WASH       = 3'd4,
        ST_RINSE      = 3'd5,
        ST_SPIN       = 3'd6
    } wash_state_t;

    // Active states are the contiguous range FILL_WATER..SPIN.
    function automatic logic is_active(input logic [2:0] s);
        return (s >= ST_FILL_WATER) && (s <= ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_actuator_decode.sv
// rtl/wash_actuator_decode.sv - combinational map from controller state to actuator enables
module wash_actuator_decode
    import wash_pkg::*;
(
    input  logic [2:0] state,
    output logic       door_lock,
    output logic       water_valve,
    output logic       heater,
    output logic       motor_wash,
    output logic       motor_spin,
    output logic       drain
);

    // Everything off by default; START, READY and the illegal code fall through to that.
    always_comb begin
        door_lock   = 1'b0;
        water_valve = 1'b0;
        heater      = 1'b0;
        motor_wash  = 1'b0;
        motor_spin  = 1'b0;
        drain       = 1'b0;
        case (state)
            ST_FILL_WATER: begin
                door_lock   = 1'b1;
                water_valve = 1'b1;
            end
            ST_HEAT_WATER: begin
                door_lock   = 1'b1;
                heater      = 1'b1;
            end
            ST_WASH: begin
                door_lock   = 1'b1;
                motor_wash  = 1'b1;
            end
            ST_RINSE: begin
                door_lock   = 1'b1;
                motor_wash  = 1'b1;
                drain       = 1'b1;
            end
            ST_SPIN: begin
                door_lock   = 1'b1;
                motor_spin  = 1'b1;
                drain       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wash_controller.sv
// rtl/wash_controller.sv - washing machine sequencer with door interlock and cycle counter
module wash_controller
    import wash_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             door_closed,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             sig_Full,
    input  logic             sig_Temperature,
    input  logic             sig_Wash_Completed,
    input  logic             sig_Rinse_Completed,
    input  logic             sig_Spin_Completed,
    output logic [2:0]       state,
    output logic             door_lock,
    output logic             water_valve,
    output logic             heater,
    output logic             motor_wash,
    output logic             motor_spin,
    output logic             drain,
    output logic             cycle_done,
    output logic             fault,
    output logic [CNT_W-1:0] cycles_completed
);

    // Plain 3-bit register so the unused code 7 is representable and recoverable.
    logic [2:0] state_q;

    assign state = state_q;

    // Sequencer: door interlock beats user stop, which beats phase advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_START;
            fault            <= 1'b0;
            cycle_done       <= 1'b0;
            cycles_completed <= '0;
        end else begin
            cycle_done <= 1'b0;
            if (is_active(state_q) && !door_closed) begin
                state_q <= ST_START;
                fault   <= 1'b1;
            end else if (is_active(state_q) && stop_btn) begin
                state_q <= ST_START;
            end else begin
                case (state_q)
                    ST_START: begin
                        if (door_closed) state_q <= ST_READY;
                    end
                    ST_READY: begin
                        if (!door_closed) begin
                            state_q <= ST_START;
                        end else if (start_btn) begin
                            state_q <= ST_FILL_WATER;
                            fault   <= 1'b0;
                        end
                    end
                    ST_FILL_WATER: begin
                        if (sig_Full) state_q <= ST_HEAT_WATER;
                    end
                    ST_HEAT_WATER: begin
                        if (sig_Temperature) state_q <= ST_WASH;
                    end
                    ST_WASH: begin
                        if (sig_Wash_Completed) state_q <= ST_RINSE;
                    end
                    ST_RINSE: begin
                        if (sig_Rinse_Completed) state_q <= ST_SPIN;
                    end
                    ST_SPIN: begin
                        if (sig_Spin_Completed) begin
                            state_q    <= ST_START;
                            cycle_done <= 1'b1;
                            if (cycles_completed != {CNT_W{1'b1}})
                                cycles_completed <= cycles_completed + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_START;
                        fault   <= 1'b1;
                    end
                endcase
            end
        end
    end

    wash_actuator_decode u_decode (
        .state       (state_q),
        .door_lock   (door_lock),
        .water_valve (water_valve),
        .heater      (heater),
        .motor_wash  (motor_wash),
        .motor_spin  (motor_spin),
        .drain       (drain)
    );

endmodule

// File: tb/tb_wash_controller.sv
// tb/tb_wash_controller.sv - directed and randomized checks of wash_controller against a reference model
module tb_wash_controller;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             door_closed;
    logic             start_btn;
    logic             stop_btn;
    logic             sig_Full;
    logic             sig_Temperature;
    logic             sig_Wash_Completed;
    logic             sig_Rinse_Completed;
    logic             sig_Spin_Completed;
    logic [2:0]       state;
    logic             door_lock;
    logic             water_valve;
    logic             heater;
    logic             motor_wash;
    logic             motor_spin;
    logic             drain;
    logic             cycle_done;
    logic             fault;
    logic [CNT_W-1:0] cycles_completed;

    int checks = 0;
    int errors = 0;

    // Reference model: state as a phase number 0..6, phases 2..6 each wait on one flag.
    int m_state;
    bit m_fault;
    bit m_done;
    int m_cnt;

    always #5 clock = ~clock;

    wash_controller #(.CNT_W(CNT_W)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .door_closed         (door_closed),
        .start_btn           (start_btn),
        .stop_btn            (stop_btn),
        .sig_Full            (sig_Full),
        .sig_Temperature     (sig_Temperature),
        .sig_Wash_Completed  (sig_Wash_Completed),
        .sig_Rinse_Completed (sig_Rinse_Completed),
        .sig_Spin_Completed  (sig_Spin_Completed),
        .state               (state),
        .door_lock           (door_lock),
        .water_valve         (water_valve),
        .heater              (heater),
        .motor_wash          (motor_wash),
        .motor_spin          (motor_spin),
        .drain               (drain),
        .cycle_done          (cycle_done),
        .fault               (fault),
        .cycles_completed    (cycles_completed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_fault = 0;
        m_done  = 0;
        m_cnt   = 0;
    endtask

    // One rising edge of the reference machine.
    task automatic model_edge();
        bit [4:0] flg;
        flg = {sig_Spin_Completed, sig_Rinse_Completed, sig_Wash_Completed,
               sig_Temperature, sig_Full};
        m_done = 0;
        if (!reset_n) begin
            model_reset();
        end else if (m_state >= 2 && m_state <= 6) begin
            if (!door_closed) begin
                m_state = 0;
                m_fault = 1;
            end else if (stop_btn) begin
                m_state = 0;
            end else if (flg[m_state-2]) begin
                if (m_state == 6) begin
                    m_state = 0;
                    m_done  = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    m_state++;
                end
            end
        end else if (m_state == 0) begin
            if (door_closed) m_state = 1;
        end else begin
            if (!door_closed) begin
                m_state = 0;
            end else if (start_btn) begin
                m_state = 2;
                m_fault = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},       32'(state),            32'(m_state));
        chk({tag, ".door_lock"},   32'(door_lock),        32'(m_state inside {[2:6]}));
        chk({tag, ".water_valve"}, 32'(water_valve),      32'(m_state == 2));
        chk({tag, ".heater"},      32'(heater),           32'(m_state == 3));
        chk({tag, ".motor_wash"},  32'(motor_wash),       32'(m_state inside {4, 5}));
        chk({tag, ".drain"},       32'(drain),            32'(m_state inside {5, 6}));
        chk({tag, ".motor_spin"},  32'(motor_spin),       32'(m_state == 6));
        chk({tag, ".cycle_done"},  32'(cycle_done),       32'(m_done));
        chk({tag, ".fault"},       32'(fault),            32'(m_fault));
        chk({tag, ".count"},       32'(cycles_completed), 32'(m_cnt));
    endtask

    task automatic set_in(input logic door, input logic start, input logic stop, input logic [4:0] f);
        door_closed         = door;
        start_btn           = start;
        stop_btn            = stop;
        sig_Full            = f[0];
        sig_Temperature     = f[1];
        sig_Wash_Completed  = f[2];
        sig_Rinse_Completed = f[3];
        sig_Spin_Completed  = f[4];
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clock);
        check_all("reset");
        reset_n = 1'b1;
    endtask

    // From START, advance to the requested state (2..6) with a clean one-hot flag each phase.
    task automatic go_to(input int target, input string tag);
        set_in(1, 0, 0, 5'b0);
        step({tag, ".ready"});
        set_in(1, 1, 0, 5'b0);
        step({tag, ".fill"});
        for (int p = 2; p < target; p++) begin
            set_in(1, 0, 0, 5'(1 << (p - 2)));
            step({tag, ".adv"});
        end
        set_in(1, 0, 0, 5'b0);
    endtask

    task automatic run_normal(input string tag);
        go_to(6, tag);
        set_in(1, 0, 0, 5'b10000);
        step({tag, ".spin_done"});
        chk({tag, ".done_lit"}, 32'(cycle_done), 32'd1);
        set_in(0, 0, 0, 5'b0);
        step({tag, ".after"});
        chk({tag, ".done_drop"}, 32'(cycle_done), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 5'b0);
        model_reset();
        #1;
        check_all("por");
        do_reset();

        // Normal cycle through every state, counter 0 -> 1.
        run_normal("normal");
        chk("normal.count_lit", 32'(cycles_completed), 32'd1);

        // Door opens during WASH: interlock fault, no completion.
        go_to(4, "door_wash");
        chk("door_wash.in_wash", 32'(state), 32'd4);
        set_in(0, 0, 0, 5'b0);
        step("door_wash.open");
        chk("door_wash.fault_lit", 32'(fault), 32'd1);
        chk("door_wash.motor_lit", 32'(motor_wash), 32'd0);
        step("door_wash.hold");

        // Recovery: close door, READY, start clears fault.
        set_in(1, 0, 0, 5'b0);
        step("recover.ready");
        chk("recover.fault_kept", 32'(fault), 32'd1);
        set_in(1, 1, 0, 5'b0);
        step("recover.fill");
        chk("recover.fault_clr", 32'(fault), 32'd0);

        // Stop alone in HEAT_WATER: abort without fault.
        set_in(1, 0, 0, 5'b00001);
        step("stop.heat");
        set_in(1, 0, 1, 5'b00010);
        step("stop.abort");
        chk("stop.no_fault", 32'(fault), 32'd0);

        // Stop and door open together in RINSE: door wins.
        go_to(5, "both");
        set_in(0, 0, 1, 5'b01000);
        step("both.abort");
        chk("both.fault_lit", 32'(fault), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                   ($urandom_range(0, 11) == 0), 5'($urandom));
            step("rand");
        end

        // Saturation: five completions on a 2-bit counter.
        do_reset();
        for (int n = 0; n < 5; n++) run_normal("sat");
        chk("sat.count_lit", 32'(cycles_completed), 32'd3);
        set_in(1, 0, 0, 5'b0);
        step("sat.hold");

        // Reset mid-SPIN with completion pending: immediate abort, no pulse.
        set_in(0, 0, 0, 5'b0);
        step("pre_spin");
        go_to(6, "rst_spin");
        set_in(1, 0, 0, 5'b10000);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_spin.async");
        chk("rst_spin.motor_lit", 32'(motor_spin), 32'd0);
        @(negedge clock);
        check_all("rst_spin.held");
        reset_n = 1'b1;
        set_in(1, 0, 0, 5'b0);
        step("rst_spin.first_edge");
        chk("rst_spin.ready_lit", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
